fire_ofm_writer: RTL and testbench
==================================

# fire_ofm_writer

Output-side collector for a fire expand layer. Captures the layer's DSP_NO-wide output vector on each sample pulse and serialises it into the feature-map RAM, one 16-bit word per cycle. Returns the one-cycle `ram_feedback` acknowledgement the layer waits on once the full WOUT×WOUT×DSP_NO map is stored and the layer has signalled finish. Sits between the expand layer's `ofm`/`sample`/`finish` outputs and the next layer's input BRAM.

## Interface
- `WOUT`, 16: output feature-map width and height; pixels per layer = WOUT**2.
- `DSP_NO`, 256: channels per output vector.
- `WIDTH`, 16: word width.
- `AW`, $clog2(WOUT**2*DSP_NO): RAM address width.
- `clk`  in  1: clock, all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `layer_sample`  in  1: one-cycle pulse; `ofm` is valid in this cycle.
- `ofm`  in  WIDTH×[0:DSP_NO-1]: output vector from the layer.
- `layer_finish`  in  1: level; the layer has ended.
- `ram_we`  out  1: RAM write enable.
- `ram_addr`  out  AW: RAM write address.
- `ram_wdata`  out  WIDTH: RAM write data.
- `ram_feedback`  out  1: one-cycle pulse, map stored and finish seen.
- `busy`  out  1: a vector is being serialised.
- `overrun`  out  1: sticky; a sample arrived while it could not be accepted.

## Operation
- States are IDLE, WRITE and DONE. Reset enters IDLE and clears all counters, `overrun` and every output.
- IDLE: a `layer_sample` with pixel_cnt < WOUT**2 copies `ofm` into the shadow registers, clears chan_cnt and moves to WRITE.
- WRITE:
  - Each cycle drives `ram_we`=1, `ram_wdata`=shadow[chan_cnt] and `ram_addr`=pixel_cnt*DSP_NO + chan_cnt, then increments chan_cnt.
  - At chan_cnt = DSP_NO-1, pixel_cnt increments.
  - The next state is WRITE again if an accepted `layer_sample` is present in that same cycle; otherwise IDLE.
- Ready: the writer accepts a sample in IDLE, or in the last WRITE cycle (chan_cnt = DSP_NO-1).
- Overrun: a `layer_sample` in any other WRITE cycle is dropped, sets `overrun`, and leaves the shadow registers and current writes untouched.
- Extra samples: samples after pixel_cnt reaches WOUT**2 are discarded silently. They do not set `overrun`, because the layer emits one trailing sample.
- Completion:
  - When pixel_cnt = WOUT**2, the state is not WRITE, and `layer_finish` = 1, the writer pulses `ram_feedback` for exactly one cycle and enters DONE.
  - DONE ignores all inputs until `rst`.
- Width rules: `ofm` words are stored unmodified (the layer has already applied ReLU and truncation). Counters are sized so that pixel_cnt can hold WOUT**2 without wrapping.
- Reset mid-WRITE aborts the vector and leaves the RAM contents undefined. The next accepted sample writes pixel 0.

## Timing
- Sample at cycle t: the shadow registers load at the edge ending t. Writes occur in cycles t+1 … t+DSP_NO.
- Sustained throughput is one vector per DSP_NO cycles. The layer's 577-cycle sample spacing leaves slack.
- Back-to-back: a sample in cycle t+DSP_NO produces its first write in cycle t+DSP_NO+1, with no bubble.
- `ram_feedback` is registered and asserts in the cycle after the completion condition is true.
- With `layer_finish` already high, `ram_feedback` therefore asserts in cycle t+DSP_NO+1 after the last sample.
- `busy` = 1 exactly in WRITE cycles. `ram_we` equals `busy`.
- Reset values:
  - `ram_we`, `ram_feedback`, `busy` and `overrun` are 0.
  - `ram_addr` and `ram_wdata` are 0.
  - The shadow registers are not reset.

## Configuration
- `FIRE_OFM_CHANNEL_MAJOR_EN`: selects the RAM address layout.
  - Defined: `ram_addr` = chan_cnt*WOUT**2 + pixel_cnt (channel planes).
  - Undefined (default): `ram_addr` = pixel_cnt*DSP_NO + chan_cnt (pixel-interleaved).
- Sequencing, timing and all other behaviour are identical in both modes.

## Test plan
- Single vector: with WOUT=2, DSP_NO=4, send one sample with ofm = {A,B,C,D}.
  - Writes occur at cycles t+1..t+4 with addr 0..3 and data A..D.
  - `busy` is high for exactly 4 cycles.
- Full layer: 4 samples at 577-cycle spacing, then `layer_finish`=1.
  - 16 writes with addr 0..15.
  - A single `ram_feedback` pulse one cycle after the condition is met.
  - A trailing 5th sample is ignored, and `overrun` stays 0.
- Back-to-back: a second sample in the last WRITE cycle.
  - The first write of pixel 1 (addr 4) occurs in the next cycle, with no idle gap.
- Overrun: a sample at chan_cnt = 1.
  - `overrun` rises and stays high.
  - The current vector's data is unchanged, and pixel_cnt advances once only.
- Late finish: all 4 pixels are written and `layer_finish` rises 10 cycles later.
  - `ram_feedback` pulses at finish+1; DONE ignores later samples.
- Reset and channel-major: `rst` mid-WRITE, then a new layer with `FIRE_OFM_CHANNEL_MAJOR_EN` defined.
  - Pixel 1 channel 2 writes to addr 2*4+1 = 9.
  - All outputs are 0 during reset.

Source files
------------

// File: rtl/fire_ofm_writer_if.sv
// rtl/fire_ofm_writer_if.sv - layer-side and RAM-side signal bundle for fire_ofm_writer
//
// Purpose: groups the expand layer's sample/finish/ofm outputs together with the
// feature-map RAM write port and writer status, so that they can be passed as one port.
//   layer_sample  layer -> writer   one-cycle pulse, ofm valid in this cycle
//   ofm           layer -> writer   DSP_NO words of WIDTH bits, ofm[0] is channel 0
//   layer_finish  layer -> writer   level, layer has ended
//   ram_we        writer -> RAM     write enable
//   ram_addr      writer -> RAM     write address
//   ram_wdata     writer -> RAM     write data
//   ram_feedback  writer -> layer   one-cycle pulse, map stored and finish seen
//   busy          writer -> status  a vector is being serialised
//   overrun       writer -> status  sticky, a sample arrived while not ready
// Modports: master = layer/RAM side (drives layer signals), slave = the writer.
interface fire_ofm_writer_if #(
    parameter int WIDTH  = 16,
    parameter int DSP_NO = 256,
    parameter int AW     = 16
);
    logic                         layer_sample;
    logic [0:DSP_NO-1][WIDTH-1:0] ofm;
    logic                         layer_finish;
    logic                         ram_we;
    logic [AW-1:0]                ram_addr;
    logic [WIDTH-1:0]             ram_wdata;
    logic                         ram_feedback;
    logic                         busy;
    logic                         overrun;

    modport master (
        output layer_sample, ofm, layer_finish,
        input  ram_we, ram_addr, ram_wdata, ram_feedback, busy, overrun
    );

    modport slave (
        input  layer_sample, ofm, layer_finish,
        output ram_we, ram_addr, ram_wdata, ram_feedback, busy, overrun
    );
endinterface

// File: rtl/fire_ofm_writer.sv
// rtl/fire_ofm_writer.sv - serialises fire expand output vectors into the feature-map RAM
//
// Purpose: captures the DSP_NO-wide ofm vector on each layer_sample into shadow
// registers and writes it to RAM one word per cycle. Once WOUT*WOUT vectors are
// stored and layer_finish is high, pulses ram_feedback once and parks in DONE
// until reset.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  slave modport of fire_ofm_writer_if (layer inputs, RAM write port, status)
// Optional feature macro: FIRE_OFM_CHANNEL_MAJOR_EN
//   defined   : ram_addr = chan_cnt*WOUT*WOUT + pixel_cnt (channel planes)
//   undefined : ram_addr = pixel_cnt*DSP_NO + chan_cnt    (pixel-interleaved)
module fire_ofm_writer #(
    parameter int WOUT   = 16,
    parameter int DSP_NO = 256,
    parameter int WIDTH  = 16,
    parameter int AW     = $clog2(WOUT*WOUT*DSP_NO)
) (
    input  logic              clk,
    input  logic              rst,
    fire_ofm_writer_if.slave  bus
);
    localparam int NPIX = WOUT * WOUT;
    // pixel_cnt must be able to hold NPIX itself, hence the +1
    localparam int PW   = $clog2(NPIX + 1);
    localparam int CW   = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
    localparam logic [PW-1:0] NPIX_P  = PW'(NPIX);
    localparam logic [CW-1:0] LAST_CH = CW'(DSP_NO - 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                       state_q, state_d;
    logic [PW-1:0]                pixel_cnt_q, pixel_cnt_d;
    logic [CW-1:0]                chan_cnt_q, chan_cnt_d;
    logic                         overrun_q, overrun_d;
    logic                         feedback_q, feedback_d;
    logic [0:DSP_NO-1][WIDTH-1:0] shadow_q, shadow_d;
    logic                         last_ch;
    logic [AW-1:0]                addr;
    logic [WIDTH-1:0]             wdata;

    assign last_ch = (state_q == WRITE) && (chan_cnt_q == LAST_CH);

    always_comb begin
        state_d     = state_q;
        pixel_cnt_d = pixel_cnt_q;
        chan_cnt_d  = chan_cnt_q;
        overrun_d   = overrun_q;
        feedback_d  = 1'b0;
        shadow_d    = shadow_q;

        case (state_q)
            IDLE, DONE: begin
            end
            WRITE: begin
                chan_cnt_d = chan_cnt_q + CW'(1);
                if (last_ch) begin
                    pixel_cnt_d = pixel_cnt_q + PW'(1);
                    state_d     = IDLE;
                end else if (bus.layer_sample) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Room is judged on the post-increment pixel count, so a sample in the
        // last write cycle of the final pixel is the silent trailing sample,
        // not the start of an out-of-range vector.
        if ((state_q == IDLE || last_ch) && bus.layer_sample && (pixel_cnt_d < NPIX_P)) begin
            shadow_d   = bus.ofm;
            chan_cnt_d = '0;
            state_d    = WRITE;
        end

        // Completion looks at next-cycle values so that, with finish already
        // high, the pulse lands in the cycle right after the last write.
        if (state_d == IDLE && pixel_cnt_d == NPIX_P && bus.layer_finish) begin
            feedback_d = 1'b1;
            state_d    = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pixel_cnt_q <= '0;
            chan_cnt_q  <= '0;
            overrun_q   <= 1'b0;
            feedback_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pixel_cnt_q <= pixel_cnt_d;
            chan_cnt_q  <= chan_cnt_d;
            overrun_q   <= overrun_d;
            feedback_q  <= feedback_d;
        end
    end

    // Shadow registers carry no reset; they are always loaded before being read.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    always_comb begin
        addr  = '0;
        wdata = '0;
        if (state_q == WRITE) begin
`ifdef FIRE_OFM_CHANNEL_MAJOR_EN
            addr = AW'(chan_cnt_q) * AW'(NPIX) + AW'(pixel_cnt_q);
`else
            addr = AW'(pixel_cnt_q) * AW'(DSP_NO) + AW'(chan_cnt_q);
`endif
            wdata = shadow_q[chan_cnt_q];
        end
    end

    assign bus.ram_we       = (state_q == WRITE);
    assign bus.busy         = (state_q == WRITE);
    assign bus.ram_addr     = addr;
    assign bus.ram_wdata    = wdata;
    assign bus.ram_feedback = feedback_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_fire_ofm_writer.sv
// tb/tb_fire_ofm_writer.sv - directed self-checking bench for fire_ofm_writer
module tb_fire_ofm_writer;
    localparam int WOUT = 2;
    localparam int DSP  = 4;
    localparam int W    = 16;
    localparam int AW   = 4;

    logic clk;
    logic rst;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    fire_ofm_writer_if #(.WIDTH(W), .DSP_NO(DSP), .AW(AW)) bus ();

    fire_ofm_writer #(.WOUT(WOUT), .DSP_NO(DSP), .WIDTH(W), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] dat(input int pix, input int ch);
        return 16'(32'hA000 + pix * 16 + ch);
    endfunction

    function automatic logic [AW-1:0] exp_addr(input int pix, input int ch);
`ifdef FIRE_OFM_CHANNEL_MAJOR_EN
        return AW'(ch * WOUT * WOUT + pix);
`else
        return AW'(pix * DSP + ch);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_pixel(input int pix);
        for (int c = 0; c < DSP; c++) bus.ofm[c] = dat(pix, c);
    endtask

    task automatic pulse_pixel(input int pix);
        load_pixel(pix);
        bus.layer_sample = 1'b1;
        tick();
        bus.layer_sample = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.layer_sample = 1'b0;
        bus.layer_finish = 1'b0;
        bus.ofm = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.layer_sample = 1'b0;
        bus.layer_finish = 1'b0;
        bus.ofm = '0;
        tick();
        tick();
        total_cnt++;
        if ({bus.ram_we, bus.busy, bus.ram_feedback, bus.overrun} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {bus.ram_we, bus.busy, bus.ram_feedback, bus.overrun});
        else pass_cnt++;
        total_cnt++;
        if (bus.ram_addr !== '0 || bus.ram_wdata !== '0) $display("FAIL reset_bus got addr %0d data %h want 0 0", bus.ram_addr, bus.ram_wdata);
        else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_vector();
        apply_reset();
        pulse_pixel(0);
        for (int c = 0; c < DSP; c++) begin
            total_cnt++;
            if (bus.ram_we !== 1'b1 || bus.busy !== 1'b1 || bus.ram_addr !== exp_addr(0, c) || bus.ram_wdata !== dat(0, c))
                $display("FAIL single_wr ch%0d got we %b busy %b addr %0d data %h want 1 1 %0d %h", c, bus.ram_we, bus.busy, bus.ram_addr, bus.ram_wdata, exp_addr(0, c), dat(0, c));
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.ram_we !== 1'b0) $display("FAIL single_end got busy %b we %b want 0 0", bus.busy, bus.ram_we);
        else pass_cnt++;
    endtask

    task automatic test_full_layer();
        int gap_we;
        apply_reset();
        for (int p = 0; p < WOUT * WOUT; p++) begin
            pulse_pixel(p);
            for (int c = 0; c < DSP; c++) begin
                total_cnt++;
                if (bus.ram_we !== 1'b1 || bus.ram_addr !== exp_addr(p, c) || bus.ram_wdata !== dat(p, c))
                    $display("FAIL full_wr p%0d ch%0d got we %b addr %0d data %h want 1 %0d %h", p, c, bus.ram_we, bus.ram_addr, bus.ram_wdata, exp_addr(p, c), dat(p, c));
                else pass_cnt++;
                tick();
            end
            gap_we = 0;
            for (int i = 0; i < 572; i++) begin
                if (bus.ram_we === 1'b1) gap_we++;
                tick();
            end
            total_cnt++;
            if (gap_we !== 0) $display("FAIL full_gap p%0d got %0d writes want 0", p, gap_we);
            else pass_cnt++;
        end
        pulse_pixel(7);
        gap_we = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.ram_we === 1'b1 || bus.busy === 1'b1) gap_we++;
            tick();
        end
        total_cnt++;
        if (gap_we !== 0 || bus.overrun !== 1'b0 || bus.ram_feedback !== 1'b0)
            $display("FAIL full_trailing got writes %0d overrun %b fb %b want 0 0 0", gap_we, bus.overrun, bus.ram_feedback);
        else pass_cnt++;
        bus.layer_finish = 1'b1;
        tick();
        total_cnt++;
        if (bus.ram_feedback !== 1'b1) $display("FAIL full_fb got %b want 1", bus.ram_feedback);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.ram_feedback !== 1'b0) $display("FAIL full_fb_single got %b want 0", bus.ram_feedback);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus.layer_finish = 1'b1;
        pulse_pixel(0);
        for (int p = 0; p < WOUT * WOUT; p++) begin
            for (int c = 0; c < DSP; c++) begin
                if (c == DSP - 1 && p < WOUT * WOUT - 1) begin
                    load_pixel(p + 1);
                    bus.layer_sample = 1'b1;
                end
                total_cnt++;
                if (bus.ram_we !== 1'b1 || bus.ram_addr !== exp_addr(p, c) || bus.ram_wdata !== dat(p, c) || bus.ram_feedback !== 1'b0)
                    $display("FAIL b2b_wr p%0d ch%0d got we %b addr %0d data %h fb %b want 1 %0d %h 0", p, c, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.ram_feedback, exp_addr(p, c), dat(p, c));
                else pass_cnt++;
                tick();
                bus.layer_sample = 1'b0;
            end
        end
        total_cnt++;
        if (bus.ram_feedback !== 1'b1 || bus.busy !== 1'b0 || bus.overrun !== 1'b0)
            $display("FAIL b2b_fb got fb %b busy %b overrun %b want 1 0 0", bus.ram_feedback, bus.busy, bus.overrun);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.ram_feedback !== 1'b0) $display("FAIL b2b_fb_single got %b want 0", bus.ram_feedback);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        apply_reset();
        pulse_pixel(0);
        for (int c = 0; c < DSP; c++) begin
            if (c == 1) begin
                load_pixel(9);
                bus.layer_sample = 1'b1;
            end
            total_cnt++;
            if (bus.ram_we !== 1'b1 || bus.ram_addr !== exp_addr(0, c) || bus.ram_wdata !== dat(0, c))
                $display("FAIL ovr_wr ch%0d got we %b addr %0d data %h want 1 %0d %h", c, bus.ram_we, bus.ram_addr, bus.ram_wdata, exp_addr(0, c), dat(0, c));
            else pass_cnt++;
            tick();
            bus.layer_sample = 1'b0;
        end
        total_cnt++;
        if (bus.overrun !== 1'b1 || bus.ram_we !== 1'b0) $display("FAIL ovr_flag got overrun %b we %b want 1 0", bus.overrun, bus.ram_we);
        else pass_cnt++;
        repeat (5) tick();
        pulse_pixel(1);
        for (int c = 0; c < DSP; c++) begin
            total_cnt++;
            if (bus.ram_we !== 1'b1 || bus.ram_addr !== exp_addr(1, c) || bus.ram_wdata !== dat(1, c))
                $display("FAIL ovr_next ch%0d got we %b addr %0d data %h want 1 %0d %h", c, bus.ram_we, bus.ram_addr, bus.ram_wdata, exp_addr(1, c), dat(1, c));
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (bus.overrun !== 1'b1) $display("FAIL ovr_sticky got %b want 1", bus.overrun);
        else pass_cnt++;
    endtask

    task automatic test_late_finish();
        int fb_seen;
        int late_we;
        apply_reset();
        for (int p = 0; p < WOUT * WOUT; p++) begin
            pulse_pixel(p);
            repeat (DSP + 2) tick();
        end
        fb_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.ram_feedback === 1'b1) fb_seen++;
            tick();
        end
        total_cnt++;
        if (fb_seen !== 0) $display("FAIL late_early_fb got %0d pulses want 0", fb_seen);
        else pass_cnt++;
        bus.layer_finish = 1'b1;
        tick();
        total_cnt++;
        if (bus.ram_feedback !== 1'b1) $display("FAIL late_fb got %b want 1", bus.ram_feedback);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.ram_feedback !== 1'b0) $display("FAIL late_fb_single got %b want 0", bus.ram_feedback);
        else pass_cnt++;
        pulse_pixel(3);
        late_we = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.ram_we === 1'b1 || bus.ram_feedback === 1'b1 || bus.overrun === 1'b1) late_we++;
            tick();
        end
        total_cnt++;
        if (late_we !== 0) $display("FAIL late_done_ignore got %0d active cycles want 0", late_we);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_write();
        logic [AW-1:0] want_p1c2;
        apply_reset();
        pulse_pixel(0);
        tick();
        rst = 1'b1;
        tick();
        total_cnt++;
        if ({bus.ram_we, bus.busy, bus.ram_feedback, bus.overrun} !== 4'b0000 || bus.ram_addr !== '0 || bus.ram_wdata !== '0)
            $display("FAIL midrst_outputs got we %b busy %b fb %b ovr %b addr %0d data %h want all 0", bus.ram_we, bus.busy, bus.ram_feedback, bus.overrun, bus.ram_addr, bus.ram_wdata);
        else pass_cnt++;
        rst = 1'b0;
        tick();
`ifdef FIRE_OFM_CHANNEL_MAJOR_EN
        want_p1c2 = 4'd9;
`else
        want_p1c2 = 4'd6;
`endif
        for (int p = 0; p < 2; p++) begin
            pulse_pixel(p);
            for (int c = 0; c < DSP; c++) begin
                total_cnt++;
                if (bus.ram_we !== 1'b1 || bus.ram_addr !== exp_addr(p, c) || bus.ram_wdata !== dat(p, c))
                    $display("FAIL midrst_wr p%0d ch%0d got we %b addr %0d data %h want 1 %0d %h", p, c, bus.ram_we, bus.ram_addr, bus.ram_wdata, exp_addr(p, c), dat(p, c));
                else pass_cnt++;
                if (p == 1 && c == 2) begin
                    total_cnt++;
                    if (bus.ram_addr !== want_p1c2) $display("FAIL midrst_p1c2_addr got %0d want %0d", bus.ram_addr, want_p1c2);
                    else pass_cnt++;
                end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_vector();
        test_full_layer();
        test_back_to_back();
        test_overrun();
        test_late_finish();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
